// File: rtl/dcache_data_responder.sv
// Cache-side responder for the MEM-stage data request interface.
// Serves single-word reads and byte-strobed writes from an internal
// word-addressed array, with programmable read and write latency so the
// requester's stall/handshake logic can be exercised before a real cache.
module dcache_data_responder #(
  parameter int ADDR_WIDTH    = 10,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] Cache_data_Address,
  input  logic        Cache_data_MemWrite,
  input  logic [31:0] Cache_data_Write_data,
  input  logic [3:0]  Cache_data_Write_strb,
  input  logic        Cache_data_MemRead,
  input  logic        Cache_data_Read_data_Ack,
  output logic        Cache_data_Mem_req_ack,
  output logic [31:0] Cache_data_Read_data,
  output logic        Cache_data_Read_data_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_DONE = 3'd2,
    RD_ACK  = 3'd3,
    RD_WAIT = 3'd4,
    RD_RESP = 3'd5
  } state_t;

  localparam logic [3:0] WL_INIT = 4'(WRITE_LATENCY - 1);
  localparam logic [3:0] RL_INIT = 4'(READ_LATENCY - 1);

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [31:0]             wdata_q;
  logic [3:0]              strb_q;
  logic [31:0]             held_q;
  logic [31:0]             word_rd;
  logic                    latch_wr, latch_rd, commit, rd_fetch, rd_load;
  logic                    ack_nxt, valid_nxt;

  logic [31:0] mem [2**ADDR_WIDTH];

  // Only the word-index bits of the byte address select a word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Cache_data_Address[31:ADDR_WIDTH+2], Cache_data_Address[1:0]};

  assign word_rd = mem[addr_q];

  // State register plus registered handshake outputs and latency counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state                      <= IDLE;
      cnt                        <= '0;
      Cache_data_Mem_req_ack     <= 1'b0;
      Cache_data_Read_data_valid <= 1'b0;
      busy                       <= 1'b0;
    end else begin
      state                      <= state_nxt;
      cnt                        <= cnt_nxt;
      Cache_data_Mem_req_ack     <= ack_nxt;
      Cache_data_Read_data_valid <= valid_nxt;
      busy                       <= (state_nxt != IDLE);
    end
  end

  // Next-state, counter and datapath-enable decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    latch_wr  = 1'b0;
    latch_rd  = 1'b0;
    commit    = 1'b0;
    rd_fetch  = 1'b0;
    rd_load   = 1'b0;
    ack_nxt   = 1'b0;
    valid_nxt = Cache_data_Read_data_valid;
    unique case (state)
      IDLE: begin
        // Write has priority; a simultaneous read stays pending on its level.
        if (Cache_data_MemWrite) begin
          latch_wr  = 1'b1;
          cnt_nxt   = WL_INIT;
          state_nxt = WR;
        end else if (Cache_data_MemRead) begin
          latch_rd  = 1'b1;
          ack_nxt   = 1'b1;
          state_nxt = RD_ACK;
        end
      end
      WR: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          commit    = 1'b1;
          ack_nxt   = 1'b1;
          state_nxt = WR_DONE;
        end
      end
      WR_DONE: state_nxt = IDLE;
      RD_ACK: begin
        rd_fetch = 1'b1;
        cnt_nxt  = RL_INIT;
        // With a single-cycle latency the response follows the ack cycle directly.
        if (READ_LATENCY <= 1) begin
          rd_load   = 1'b1;
          valid_nxt = 1'b1;
          state_nxt = RD_RESP;
        end else begin
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt <= 4'd1) begin
          cnt_nxt   = 4'd0;
          rd_load   = 1'b1;
          valid_nxt = 1'b1;
          state_nxt = RD_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RD_RESP: begin
        if (Cache_data_Read_data_Ack) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latched request fields, held read word and read-data output register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q               <= '0;
      wdata_q              <= '0;
      strb_q               <= '0;
      held_q               <= '0;
      Cache_data_Read_data <= '0;
    end else begin
      if (latch_wr) begin
        addr_q  <= Cache_data_Address[ADDR_WIDTH+1:2];
        wdata_q <= Cache_data_Write_data;
        strb_q  <= Cache_data_Write_strb;
      end else if (latch_rd) begin
        addr_q <= Cache_data_Address[ADDR_WIDTH+1:2];
      end
      if (rd_fetch) begin
        held_q <= word_rd;
      end
      if (rd_load) begin
        Cache_data_Read_data <= (state == RD_ACK) ? word_rd : held_q;
      end
    end
  end

  // Byte-masked array commit; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (resetn && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (strb_q[i]) begin
          mem[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_data_responder.sv
// Scoreboard bench for dcache_data_responder: a driver issues requests and
// queues expected ack cycles and read responses from a behavioural array
// model; a monitor compares whatever the DUT presents against the queues.
module tb_dcache_data_responder;

  localparam int AW = 10;
  localparam int RL = 2;
  localparam int WL = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] address = '0;
  logic        mem_write = 1'b0;
  logic [31:0] write_data = '0;
  logic [3:0]  write_strb = '0;
  logic        mem_read = 1'b0;
  logic        rd_ack = 1'b0;
  logic        req_ack;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;

  dcache_data_responder #(
    .ADDR_WIDTH(AW), .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .Cache_data_Address(address),
    .Cache_data_MemWrite(mem_write),
    .Cache_data_Write_data(write_data),
    .Cache_data_Write_strb(write_strb),
    .Cache_data_MemRead(mem_read),
    .Cache_data_Read_data_Ack(rd_ack),
    .Cache_data_Mem_req_ack(req_ack),
    .Cache_data_Read_data(rd_data),
    .Cache_data_Read_data_valid(rd_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rd_t;

  logic [31:0] ref_mem [0:(1<<AW)-1];
  int          ack_q[$];
  rd_t         rd_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endfunction

  function automatic void flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endfunction

  // Monitor: outputs are sampled on the falling edge.
  logic        prev_ack = 1'b0;
  logic        prev_valid = 1'b0;
  logic        samp_rack = 1'b0;
  logic [31:0] prev_data = '0;
  int          exp_cyc;
  rd_t         exp_rd;

  always @(posedge clk) samp_rack <= rd_ack;

  always @(negedge clk) begin
    if (req_ack) begin
      if (ack_q.size() == 0) begin
        flag("unexpected_req_ack");
      end else begin
        exp_cyc = ack_q.pop_front();
        chk("req_ack_cycle", 32'(cyc), 32'(exp_cyc));
        chk("busy_during_ack", 32'(busy), 32'd1);
      end
    end
    if (prev_ack) chk("req_ack_single_pulse", 32'(req_ack), 32'd0);
    if (rd_valid && !prev_valid) begin
      if (rd_q.size() == 0) begin
        flag("unexpected_read_valid");
      end else begin
        exp_rd = rd_q.pop_front();
        chk("read_data", rd_data, exp_rd.data);
        chk("read_valid_cycle", 32'(cyc), 32'(exp_rd.cyc));
      end
    end
    if (prev_valid && !samp_rack) begin
      chk("valid_held", 32'(rd_valid), 32'd1);
      chk("data_held", rd_data, prev_data);
    end
    if (prev_valid && samp_rack) begin
      chk("valid_drop_after_ack", 32'(rd_valid), 32'd0);
      chk("data_kept_after_ack", rd_data, prev_data);
    end
    prev_ack   = req_ack;
    prev_valid = rd_valid;
    prev_data  = rd_data;
  end

  // Driver helpers.
  task automatic wait_req_ack(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ack) return;
    end
    flag(name);
  endtask

  task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) ref_mem[idx][8*i +: 8] = d[8*i +: 8];
  endtask

  // One transaction; called on a falling edge while the DUT is idle.
  task automatic txn(input bit wr, input bit rd, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s, input int hold);
    int  c;
    int  rs;
    int  idx;
    bit  seen;
    rd_t r;
    c   = cyc;
    idx = int'(a[AW+1:2]);
    if (wr) begin
      ack_q.push_back(c + 1 + WL);
      model_write(idx, d, s);
    end
    if (rd) begin
      rs = wr ? (c + 3 + WL) : (c + 1);
      ack_q.push_back(rs);
      r.data = ref_mem[idx];
      r.cyc  = rs + RL;
      rd_q.push_back(r);
    end
    address    = a;
    write_data = d;
    write_strb = s;
    mem_write  = wr;
    mem_read   = rd;
    if (wr) begin
      wait_req_ack("timeout_write_ack");
      mem_write = 1'b0;
      @(negedge clk);
    end
    if (rd) begin
      wait_req_ack("timeout_read_ack");
      mem_read = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        if (rd_valid) seen = 1'b1;
        else begin
          rd_ack = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
      if (!seen) flag("timeout_read_valid");
      rd_ack = (hold == 0);
      repeat (hold) @(negedge clk);
      rd_ack = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (!rd_valid) seen = 1'b1;
      end
      if (!seen) flag("timeout_valid_drop");
      rd_ack = 1'b0;
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ack"}, 32'(req_ack), 32'd0);
    chk({tag, "_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_data"}, rd_data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Read aborted by a one-edge reset while waiting for data.
  task automatic rd_reset(input logic [31:0] a);
    ack_q.push_back(cyc + 1);
    address  = a;
    mem_read = 1'b1;
    wait_req_ack("timeout_abort_read_ack");
    mem_read = 1'b0;
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_rd_wait");
    resetn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // Write aborted by a one-edge reset before its commit edge.
  task automatic wr_reset(input logic [31:0] a, input logic [31:0] d);
    address    = a;
    write_data = d;
    write_strb = 4'hF;
    mem_write  = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
    resetn    = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_wr");
    resetn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  logic [AW-1:0] pool [8];

  initial begin
    logic [31:0]   rnd;
    logic [31:0]   a;
    logic [AW-1:0] ix;
    int            op;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);

    txn(1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 4'hF, 0);
    txn(1'b0, 1'b1, 32'h40, 32'h0, 4'h0, 0);
    txn(1'b1, 1'b0, 32'h80, 32'h11223344, 4'hF, 0);
    txn(1'b1, 1'b0, 32'h80, 32'hAABBCCDD, 4'b0101, 0);
    txn(1'b0, 1'b1, 32'h80, 32'h0, 4'h0, 0);
    txn(1'b0, 1'b1, 32'h40, 32'h0, 4'h0, 5);
    txn(1'b1, 1'b1, 32'h10, 32'h5, 4'hF, 0);
    txn(1'b1, 1'b0, 32'h1000, 32'h12345678, 4'hF, 0);
    txn(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 1);
    txn(1'b1, 1'b0, 32'h40, 32'hFFFFFFFF, 4'h0, 0);
    txn(1'b0, 1'b1, 32'h40, 32'h0, 4'h0, 0);

    rd_reset(32'h40);
    wr_reset(32'h80, 32'hCAFEF00D);
    txn(1'b0, 1'b1, 32'h80, 32'h0, 4'h0, 0);

    for (int i = 0; i < 8; i++) begin
      pool[i] = AW'($urandom_range(0, (1 << AW) - 1));
      txn(1'b1, 1'b0, {20'h0, pool[i], 2'b00}, $urandom, 4'hF, 0);
    end
    for (int i = 0; i < 40; i++) begin
      rnd = $urandom;
      ix  = pool[$urandom_range(0, 7)];
      a   = {rnd[31:AW+2], ix, rnd[1:0]};
      op  = $urandom_range(0, 2);
      txn(op != 1, op != 0, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    repeat (10) @(negedge clk);
    chk("ack_queue_drained", 32'(ack_q.size()), 32'd0);
    chk("read_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "simulation time limit reached");
  end

endmodule
